// File: rtl/i2s_frame_clock_gen.sv
// rtl/i2s_frame_clock_gen.sv - I2S/TDM SCLK and LRCLK/FSYNC generator with frame position strobes
// Optional MCLK divider: define I2S_CLKGEN_MCLK_EN to add mclk_half_div / mclk_out.
module i2s_frame_clock_gen #(
  parameter int DIV_W     = 8,
  parameter int SLOT_BITS = 16,
  parameter int CHANNELS  = 2,
  localparam int FRAME_BITS = SLOT_BITS * CHANNELS,
  localparam int BIT_W      = $clog2(SLOT_BITS),
  localparam int SLOT_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  sclk_half_div,
  input  logic              mode_tdm,
`ifdef I2S_CLKGEN_MCLK_EN
  input  logic [DIV_W-1:0]  mclk_half_div,
  output logic              mclk_out,
`endif
  output logic              sclk_out,
  output logic              lrclk_out,
  output logic              sclk_rise_stb,
  output logic              sclk_fall_stb,
  output logic              frame_start,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [BIT_W-1:0]  bit_idx,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  half_cnt_q, half_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              mode_q, mode_d;
  logic              sclk_q, sclk_d;
  logic              lrclk_q, lrclk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  logic [SLOT_W-1:0] slot_nx;
  logic [BIT_W-1:0]  bit_nx;
  logic              wrap;

  // Frame clock level for position p = slot*SLOT_BITS + bit; I2S LRCLK leads the MSB by one bit.
  function automatic logic lr_for(input logic [SLOT_W-1:0] slot, input logic [BIT_W-1:0] bitn,
                                  input logic tdm);
    logic [31:0] p;
    p = 32'(slot) * 32'(SLOT_BITS) + 32'(bitn);
    if (tdm) begin
      return p == 32'(FRAME_BITS - 1);
    end
    return (p >= 32'(FRAME_BITS / 2 - 1)) && (p <= 32'(FRAME_BITS - 2));
  endfunction

  // Position one falling edge ahead, and whether that edge wraps the frame.
  always_comb begin
    slot_nx = slot_q;
    bit_nx  = bit_q + 1'b1;
    wrap    = 1'b0;
    if (bit_q == BIT_LAST) begin
      bit_nx = '0;
      if (slot_q == SLOT_LAST) begin
        slot_nx = '0;
        wrap    = 1'b1;
      end else begin
        slot_nx = slot_q + 1'b1;
      end
    end
  end

  // Control FSM: divider, SCLK toggling, position tracking, frame-aligned start/stop.
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    div_d      = div_q;
    mode_d     = mode_q;
    sclk_d     = sclk_q;
    lrclk_d    = lrclk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    fs_d       = 1'b0;
    busy_d     = busy_q;
    slot_d     = slot_q;
    bit_d      = bit_q;
    case (state_q)
      ST_IDLE: begin
        sclk_d  = 1'b0;
        lrclk_d = 1'b0;
        busy_d  = 1'b0;
        if (enable) begin
          div_d      = sclk_half_div;
          mode_d     = mode_tdm;
          slot_d     = SLOT_LAST;
          bit_d      = BIT_LAST;
          lrclk_d    = lr_for(SLOT_LAST, BIT_LAST, mode_tdm);
          half_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (half_cnt_q == div_q) begin
          half_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rise_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (wrap && !enable) begin
              // Stop only at a frame boundary; the edge itself is not announced.
              lrclk_d = 1'b0;
              slot_d  = '0;
              bit_d   = '0;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              fall_d  = 1'b1;
              slot_d  = slot_nx;
              bit_d   = bit_nx;
              lrclk_d = lr_for(slot_nx, bit_nx, mode_q);
              if (wrap) begin
                fs_d   = 1'b1;
                div_d  = sclk_half_div;
                mode_d = mode_tdm;
              end
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      half_cnt_q <= '0;
      div_q      <= sclk_half_div;
      mode_q     <= mode_tdm;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
      slot_q     <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
      slot_q     <= slot_d;
      bit_q      <= bit_d;
    end
  end

  assign sclk_out      = sclk_q;
  assign lrclk_out     = lrclk_q;
  assign sclk_rise_stb = rise_q;
  assign sclk_fall_stb = fall_q;
  assign frame_start   = fs_q;
  assign slot_idx      = slot_q;
  assign bit_idx       = bit_q;
  assign busy          = busy_q;

`ifdef I2S_CLKGEN_MCLK_EN
  logic [DIV_W-1:0] mclk_cnt_q, mclk_cnt_d;
  logic             mclk_q, mclk_d;

  // Free-running MCLK divider; >= lets a shrinking divisor take effect immediately.
  always_comb begin
    mclk_cnt_d = mclk_cnt_q + 1'b1;
    mclk_d     = mclk_q;
    if (mclk_cnt_q >= mclk_half_div) begin
      mclk_cnt_d = '0;
      mclk_d     = ~mclk_q;
    end
  end

  // MCLK registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      mclk_q     <= mclk_d;
    end
  end

  assign mclk_out = mclk_q;
`endif

endmodule

// File: tb/tb_i2s_frame_clock_gen.sv
// tb/tb_i2s_frame_clock_gen.sv - scoreboard bench for i2s_frame_clock_gen (I2S and TDM instances)
module tb_i2s_frame_clock_gen;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, en_a, mode_a;
  logic [7:0] div_a;
  logic       sclk_a, lr_a, rise_a, fall_a, fs_a, busy_a;
  logic [0:0] slot_a;
  logic [3:0] bit_a;

  logic       rst_b, en_b, mode_b;
  logic [7:0] div_b;
  logic       sclk_b, lr_b, rise_b, fall_b, fs_b, busy_b;
  logic [2:0] slot_b;
  logic [4:0] bit_b;

`ifdef I2S_CLKGEN_MCLK_EN
  logic [7:0] mdiv_a, mdiv_b;
  logic       mclk_a, mclk_b;
`endif

  ev_t a_snap[$], a_lr[$], b_snap[$], b_lr[$];
  int  a_fs[$], b_fs[$];
  int  n_chk = 0;
  int  n_pass = 0;
  logic a_lr_prev = 1'b0;
  logic b_lr_prev = 1'b0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;

  i2s_frame_clock_gen #(.DIV_W(8), .SLOT_BITS(16), .CHANNELS(2)) u_a (
    .clk_in(clk), .reset(rst_a), .enable(en_a), .sclk_half_div(div_a), .mode_tdm(mode_a),
`ifdef I2S_CLKGEN_MCLK_EN
    .mclk_half_div(mdiv_a), .mclk_out(mclk_a),
`endif
    .sclk_out(sclk_a), .lrclk_out(lr_a), .sclk_rise_stb(rise_a), .sclk_fall_stb(fall_a),
    .frame_start(fs_a), .slot_idx(slot_a), .bit_idx(bit_a), .busy(busy_a)
  );

  i2s_frame_clock_gen #(.DIV_W(8), .SLOT_BITS(32), .CHANNELS(8)) u_b (
    .clk_in(clk), .reset(rst_b), .enable(en_b), .sclk_half_div(div_b), .mode_tdm(mode_b),
`ifdef I2S_CLKGEN_MCLK_EN
    .mclk_half_div(mdiv_b), .mclk_out(mclk_b),
`endif
    .sclk_out(sclk_b), .lrclk_out(lr_b), .sclk_rise_stb(rise_b), .sclk_fall_stb(fall_b),
    .frame_start(fs_b), .slot_idx(slot_b), .bit_idx(bit_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pk(input int s, input int l, input int r, input int f, input int fs,
                            input int b, input int slot, input int bitn);
    return (s << 15) | (l << 14) | (r << 13) | (f << 12) | (fs << 11) | (b << 10) | (slot << 5) | bitn;
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic snap_a(input int c, input int v);
    ev_t e;
    e.cyc = c; e.val = v;
    a_snap.push_back(e);
  endtask

  task automatic snap_b(input int c, input int v);
    ev_t e;
    e.cyc = c; e.val = v;
    b_snap.push_back(e);
  endtask

  task automatic lr_b_push(input int c, input int v);
    ev_t e;
    e.cyc = c; e.val = v;
    b_lr.push_back(e);
  endtask

  // I2S frame starting at f with SCLK period per: LRCLK rises entering p=15, falls entering p=31.
  task automatic lr_a_frame(input int f, input int per);
    ev_t e;
    e.cyc = f + 15 * per; e.val = 1;
    a_lr.push_back(e);
    e.cyc = f + 31 * per; e.val = 0;
    a_lr.push_back(e);
  endtask

  // Monitor for the I2S instance.
  always @(negedge clk) begin : mon_a
    ev_t e;
    if (cyc >= 3) begin
      if (a_snap.size() > 0 && a_snap[0].cyc == cyc) begin
        e = a_snap.pop_front();
        check("a_snapshot", pk(int'(sclk_a), int'(lr_a), int'(rise_a), int'(fall_a), int'(fs_a),
                               int'(busy_a), int'(slot_a), int'(bit_a)), e.val);
      end
      if (fs_a) begin
        if (a_fs.size() == 0) check("a_frame_start_unexpected", cyc, -1);
        else check("a_frame_start_cycle", cyc, a_fs.pop_front());
      end
      if (lr_a !== a_lr_prev) begin
        a_lr_prev = lr_a;
        if (a_lr.size() == 0) check("a_lrclk_unexpected", cyc, -1);
        else begin
          e = a_lr.pop_front();
          check("a_lrclk_cycle", cyc, e.cyc);
          check("a_lrclk_level", int'(lr_a), e.val);
        end
      end
    end
  end

  // Monitor for the TDM instance.
  always @(negedge clk) begin : mon_b
    ev_t e;
    if (cyc >= 3) begin
      if (b_snap.size() > 0 && b_snap[0].cyc == cyc) begin
        e = b_snap.pop_front();
        check("b_snapshot", pk(int'(sclk_b), int'(lr_b), int'(rise_b), int'(fall_b), int'(fs_b),
                               int'(busy_b), int'(slot_b), int'(bit_b)), e.val);
      end
      if (fs_b) begin
        if (b_fs.size() == 0) check("b_frame_start_unexpected", cyc, -1);
        else check("b_frame_start_cycle", cyc, b_fs.pop_front());
      end
      if (lr_b !== b_lr_prev) begin
        b_lr_prev = lr_b;
        if (b_lr.size() == 0) check("b_fsync_unexpected", cyc, -1);
        else begin
          e = b_lr.pop_front();
          check("b_fsync_cycle", cyc, e.cyc);
          check("b_fsync_level", int'(lr_b), e.val);
        end
      end
    end
  end

  // I2S stimulus: start, rate change, frame-aligned stop, restart, mid-frame reset, div=0.
  initial begin
    int n, m;
    rst_a = 1'b1; en_a = 1'b0; div_a = 8'd11; mode_a = 1'b0;
    repeat (3) @(negedge clk);
    snap_a(4, 0);
    @(negedge clk);
    rst_a = 1'b0;
    snap_a(6, 0);
    wait_to(10);
    n = 10;
    snap_a(n + 1,   pk(0, 0, 0, 0, 0, 1, 1, 15));
    snap_a(n + 13,  pk(1, 0, 1, 0, 0, 1, 1, 15));
    snap_a(n + 25,  pk(0, 0, 0, 1, 1, 1, 0, 0));
    snap_a(n + 49,  pk(0, 0, 0, 1, 0, 1, 0, 1));
    snap_a(n + 409, pk(0, 1, 0, 1, 0, 1, 1, 0));
    a_fs.push_back(n + 25);
    a_fs.push_back(n + 793);
    a_fs.push_back(n + 1561);
    a_fs.push_back(n + 2329);
    a_fs.push_back(n + 2713);
    lr_a_frame(n + 25, 24);
    lr_a_frame(n + 793, 24);
    lr_a_frame(n + 1561, 24);
    lr_a_frame(n + 2329, 12);
    lr_a_frame(n + 2713, 12);
    en_a = 1'b1;
    wait_to(n + 1801);
    div_a = 8'd5;
    wait_to(n + 2953);
    en_a = 1'b0;
    div_a = 8'd11;
    snap_a(n + 3096, pk(1, 0, 0, 0, 0, 1, 1, 15));
    snap_a(n + 3097, 0);
    wait_to(n + 3110);
    a_fs.push_back(n + 3135);
    snap_a(n + 3111, pk(0, 0, 0, 0, 0, 1, 1, 15));
    snap_a(n + 3308, pk(0, 0, 0, 0, 0, 1, 0, 7));
    snap_a(n + 3309, 0);
    en_a = 1'b1;
    wait_to(n + 3308);
    rst_a = 1'b1;
    en_a = 1'b0;
    wait_to(n + 3312);
    rst_a = 1'b0;
    snap_a(n + 3316, 0);
    wait_to(n + 3320);
    m = n + 3320;
    div_a = 8'd0;
    snap_a(m + 2,   pk(1, 0, 1, 0, 0, 1, 1, 15));
    snap_a(m + 3,   pk(0, 0, 0, 1, 1, 1, 0, 0));
    snap_a(m + 4,   pk(1, 0, 1, 0, 0, 1, 0, 0));
    snap_a(m + 5,   pk(0, 0, 0, 1, 0, 1, 0, 1));
    snap_a(m + 130, pk(1, 0, 1, 0, 0, 1, 1, 15));
    snap_a(m + 131, 0);
    a_fs.push_back(m + 3);
    a_fs.push_back(m + 67);
    lr_a_frame(m + 3, 2);
    lr_a_frame(m + 67, 2);
    en_a = 1'b1;
    wait_to(m + 70);
    en_a = 1'b0;
    wait_to(m + 140);
    done_a = 1'b1;
  end

  // TDM stimulus: 8 slots x 32 bits, div=1, three frames then stop.
  initial begin
    int k, f;
    rst_b = 1'b1; en_b = 1'b0; div_b = 8'd1; mode_b = 1'b1;
    repeat (3) @(negedge clk);
    snap_b(4, 0);
    @(negedge clk);
    rst_b = 1'b0;
    wait_to(8);
    k = 8;
    f = k + 5;
    lr_b_push(k + 1, 1);
    lr_b_push(k + 5, 0);
    snap_b(k + 1,    pk(0, 1, 0, 0, 0, 1, 7, 31));
    snap_b(k + 5,    pk(0, 0, 0, 1, 1, 1, 0, 0));
    snap_b(f + 384,  pk(0, 0, 0, 1, 0, 1, 3, 0));
    snap_b(f + 1020, pk(0, 1, 0, 1, 0, 1, 7, 31));
    snap_b(f + 3072, 0);
    for (int i = 0; i < 3; i++) begin
      b_fs.push_back(f + 1024 * i);
      lr_b_push(f + 1024 * i + 1020, 1);
      lr_b_push(f + 1024 * (i + 1), 0);
    end
    en_b = 1'b1;
    wait_to(f + 2058);
    en_b = 1'b0;
    wait_to(f + 3080);
    done_b = 1'b1;
  end

`ifdef I2S_CLKGEN_MCLK_EN
  // MCLK: half divider 1 gives period 4 from reset release, independent of enable.
  initial begin
    mdiv_a = 8'd1;
    mdiv_b = 8'd0;
    wait_to(6);
    for (int i = 0; i < 8; i++) begin
      check("mclk_level", int'(mclk_a), ((i / 2) % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
  end
`endif

  // Completion, leftover-expectation checks and summary.
  initial begin
    while (!(done_a && done_b) && cyc < 12000) @(negedge clk);
    check("run_complete", int'(done_a && done_b), 1);
    @(negedge clk);
    check("a_snap_pending", a_snap.size(), 0);
    check("a_fs_pending", a_fs.size(), 0);
    check("a_lr_pending", a_lr.size(), 0);
    check("b_snap_pending", b_snap.size(), 0);
    check("b_fs_pending", b_fs.size(), 0);
    check("b_lr_pending", b_lr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
